// File: rtl/spi_target_pkg.sv
// spi_target_pkg
//   Shared types and constants for the SPI register-file responder.
//   state_t        : responder FSM state encoding
//   CMD_READ_BIT   : command-byte bit selecting read (1) or write (0)
//   ADDR_W         : register-file address width (16 registers)
//   DEV_ID_DEFAULT : identification byte shifted out during the command byte
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int         CMD_READ_BIT   = 7;
    localparam int         ADDR_W         = 4;
    localparam logic [7:0] DEV_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchronizer for an asynchronous input, followed by one history
//   flop that produces single-cycle rise/fall pulses on the synchronized value.
//   Ports:
//     CLK     in  system clock
//     RST     in  synchronous active-high reset
//     d       in  asynchronous input
//     rise    out one-cycle pulse on a synchronized 0->1 transition
//     fall    out one-cycle pulse on a synchronized 1->0 transition
//   RST_VAL is the level the flops take in reset; choosing it equal to the
//   signal's idle level prevents a spurious edge when reset is released.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_target.sv
// spi_target
//   Oversampled SPI responder exposing a 16-byte register file. The first
//   byte of a transfer is a command (bit 7 = read, bits 3:0 = start address);
//   following bytes are written to or read from auto-incrementing addresses.
//   Ports:
//     CLK, RST        system clock, synchronous active-high reset
//     SCK, MOSI, nSS  asynchronous SPI bus from the master
//     MISO, MISO_OE   responder data and its output-buffer enable
//     RADDR / RDATA   fabric read port, combinational
//     WSTB            one-cycle pulse per completed SPI write byte
//     WADDR / WDATA   address and data of the last SPI write
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | deselected, MISO_OE low, waiting for nSS to fall
//   ST_CMD  | shifting in the command byte, shifting out DEV_ID
//   ST_DATA | data bytes: write to regs, or stream regs out on MISO
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic       CPOL   = 1'b0,
    parameter logic [7:0] DEV_ID = DEV_ID_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              nSS,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [ADDR_W-1:0] RADDR,
    output logic [7:0]        RDATA,
    output logic              WSTB,
    output logic [ADDR_W-1:0] WADDR,
    output logic [7:0]        WDATA
);

    logic              sck_rise, sck_fall, nss_rise, nss_fall;
    logic              mosi_s1, mosi_s2;
    state_t            state;
    logic [2:0]        bitcnt;
    logic [6:0]        sr_in;
    logic [7:0]        rx_byte;
    logic [7:0]        sr_out;
    logic [7:0]        tx_next;
    logic              load_next;
    logic              skip_fall;
    logic              is_read;
    logic [ADDR_W-1:0] addr, addr_inc;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        regs [0:(1<<ADDR_W)-1];

    // nSS synchronizer resets low so a select already asserted when reset is
    // released produces no falling edge; the master must raise nSS first.
    spi_sync_edge #(.RST_VAL(CPOL)) u_sck (
        .CLK  (CLK),
        .RST  (RST),
        .d    (SCK),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_nss (
        .CLK  (CLK),
        .RST  (RST),
        .d    (nSS),
        .rise (nss_rise),
        .fall (nss_fall)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign rx_byte  = {sr_in, mosi_s2};
    assign addr_inc = addr + ADDR_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            bitcnt    <= 3'd0;
            sr_in     <= 7'd0;
            sr_out    <= 8'd0;
            tx_next   <= 8'd0;
            load_next <= 1'b0;
            skip_fall <= 1'b0;
            is_read   <= 1'b0;
            addr      <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
        end else begin
            wr_pend <= 1'b0;
            // Deselect has priority over a byte completing in the same cycle.
            if (nss_rise) begin
                state     <= ST_IDLE;
                sr_out    <= 8'd0;
                load_next <= 1'b0;
                skip_fall <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (nss_fall) begin
                            state     <= ST_CMD;
                            bitcnt    <= 3'd0;
                            sr_out    <= DEV_ID;
                            load_next <= 1'b0;
                            // In mode 3 the first falling edge only moves SCK
                            // off its idle level; DEV_ID's MSB must stay put.
                            skip_fall <= CPOL;
                        end
                    end
                    default: begin
                        if (sck_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            sr_in  <= rx_byte[6:0];
                            if (bitcnt == 3'd7) begin
                                if (state == ST_CMD) begin
                                    state   <= ST_DATA;
                                    is_read <= rx_byte[CMD_READ_BIT];
                                    addr    <= rx_byte[ADDR_W-1:0];
                                    if (rx_byte[CMD_READ_BIT]) begin
                                        tx_next   <= regs[rx_byte[ADDR_W-1:0]];
                                        load_next <= 1'b1;
                                    end
                                end else if (is_read) begin
                                    addr      <= addr_inc;
                                    tx_next   <= regs[addr_inc];
                                    load_next <= 1'b1;
                                end else begin
                                    wr_pend <= 1'b1;
                                    wr_addr <= addr;
                                    wr_data <= rx_byte;
                                    addr    <= addr_inc;
                                end
                            end
                        end
                        // A prepared byte replaces the shift on the falling
                        // edge that follows the 8th sampling edge.
                        if (sck_fall) begin
                            if (skip_fall) begin
                                skip_fall <= 1'b0;
                            end else if (load_next) begin
                                sr_out    <= tx_next;
                                load_next <= 1'b0;
                            end else begin
                                sr_out <= {sr_out[6:0], 1'b0};
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Register contents deliberately survive RST so a controller reset in the
    // middle of a transfer does not lose configuration held in the file.
    always_ff @(posedge CLK) begin
        if (wr_pend) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WSTB  <= 1'b0;
            WADDR <= '0;
            WDATA <= 8'd0;
        end else begin
            WSTB <= wr_pend;
            if (wr_pend) begin
                WADDR <= wr_addr;
                WDATA <= wr_data;
            end
        end
    end

    assign MISO    = sr_out[7];
    assign MISO_OE = (state != ST_IDLE);
    assign RDATA   = regs[RADDR];

endmodule
